// File: rtl/mem_block_copier_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_block_copier_if
// Purpose : Bundles the control handshake and the single-port memory bus of
//           the mem_block_copier block-copy initiator.
// Signals :
//   start       request pulse, sampled only while the copier is idle
//   src_addr    first source word address
//   dst_addr    first destination word address
//   len         number of words to copy (0 is legal)
//   busy        copier owns the memory port
//   done        one-cycle end-of-transfer pulse
//   mem_regWE   memory write enable
//   mem_Addr    memory address
//   mem_wdata   memory write data
//   mem_rdata   combinational memory read data
//   fill        (MEM_COPIER_FILL_EN only) write fill_value instead of copying
//   fill_value  (MEM_COPIER_FILL_EN only) constant word written in fill mode
// Modports: master = copier side, slave = requester/memory side.
// Configuration macro: MEM_COPIER_FILL_EN
// -----------------------------------------------------------------------------
interface mem_block_copier_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 10
);
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              mem_regWE;
    logic [ADDR_W-1:0] mem_Addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_COPIER_FILL_EN
    logic              fill;
    logic [DATA_W-1:0] fill_value;

    modport master (
        input  start, src_addr, dst_addr, len, mem_rdata, fill, fill_value,
        output busy, done, mem_regWE, mem_Addr, mem_wdata
    );
    modport slave (
        output start, src_addr, dst_addr, len, mem_rdata, fill, fill_value,
        input  busy, done, mem_regWE, mem_Addr, mem_wdata
    );
`else
    modport master (
        input  start, src_addr, dst_addr, len, mem_rdata,
        output busy, done, mem_regWE, mem_Addr, mem_wdata
    );
    modport slave (
        output start, src_addr, dst_addr, len, mem_rdata,
        input  busy, done, mem_regWE, mem_Addr, mem_wdata
    );
`endif
endinterface

// File: rtl/mem_block_copier.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_block_copier
// Purpose : Simple DMA beside the core. On an accepted start it copies len
//           words from src_addr to dst_addr through the single-port memory,
//           one access per cycle: READ then WRITE, 2 cycles per word, strictly
//           ascending. The core owns the memory port whenever busy is low.
// Ports   :
//   clk    system clock, all state on posedge
//   rst_n  asynchronous active-low reset; abandons any transfer in flight
//   bus    mem_block_copier_if.master (start/src_addr/dst_addr/len in,
//          busy/done out, memory bus mem_regWE/mem_Addr/mem_wdata out,
//          mem_rdata in)
// Configuration macro: MEM_COPIER_FILL_EN
//   When defined, fill/fill_value are captured with start; fill=1 skips READ
//   and writes fill_value to len consecutive words, 1 cycle per word.
// Parameters of the interface instance must match ADDR_W/DATA_W/LEN_W.
// -----------------------------------------------------------------------------
module mem_block_copier #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_block_copier_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_rem;
    // Memory-side outputs are registered: they are loaded together with the
    // state they belong to, so nothing on the memory port depends
    // combinationally on start/len, and address/data naturally hold their
    // last value when not being updated.
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
`ifdef MEM_COPIER_FILL_EN
    logic              r_fill;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_rem       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef MEM_COPIER_FILL_EN
            r_fill      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_src <= bus.src_addr;
                        r_dst <= bus.dst_addr;
                        r_rem <= bus.len;
`ifdef MEM_COPIER_FILL_EN
                        r_fill <= bus.fill;
`endif
                        if (bus.len == '0) begin
                            r_state <= S_DONE;
                        end
`ifdef MEM_COPIER_FILL_EN
                        else if (bus.fill) begin
                            // Fill mode: the data word is constant for the
                            // whole transfer, so load it once here.
                            r_state     <= S_WRITE;
                            r_mem_addr  <= bus.dst_addr;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= bus.fill_value;
                        end
`endif
                        else begin
                            r_state    <= S_READ;
                            r_mem_addr <= bus.src_addr;
                            r_mem_we   <= 1'b0;
                        end
                    end
                end
                S_READ: begin
                    // The write-data register doubles as the read holding
                    // register: it captures the word being read.
                    r_mem_wdata <= bus.mem_rdata;
                    r_mem_addr  <= r_dst;
                    r_mem_we    <= 1'b1;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    r_src <= r_src + ADDR_ONE;
                    r_dst <= r_dst + ADDR_ONE;
                    r_rem <= r_rem - LEN_ONE;
                    if (r_rem > LEN_ONE) begin
`ifdef MEM_COPIER_FILL_EN
                        if (r_fill) begin
                            r_state    <= S_WRITE;
                            r_mem_addr <= r_dst + ADDR_ONE;
                        end else
`endif
                        begin
                            r_state    <= S_READ;
                            r_mem_addr <= r_src + ADDR_ONE;
                            r_mem_we   <= 1'b0;
                        end
                    end else begin
                        r_state  <= S_DONE;
                        r_mem_we <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.mem_regWE = r_mem_we;
    assign bus.mem_Addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule
